pipe_hazard_ctrl: RTL and testbench

Parametrised hazard and forwarding controller for the pipelined RV32 core. It tracks in-flight register writes over DEPTH post-decode stages (EX, MEM, WB, ...) with an internal scoreboard shift register. It raises load-use stalls, selects forwarding sources for rs1/rs2, and flushes wrong-path instructions on jumps resolved in EX. Saturating performance counters record stall and flush cycles.

---
 rtl/pipe_hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Hazard and forwarding controller for the pipelined RV32 core. It keeps a
// shift-register scoreboard of in-flight register writes for the DEPTH stages
// after ID. From that scoreboard it produces forwarding selects, load-use
// stalls and jump flushes, and it keeps saturating stall and flush counters.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   id_*                  ID-stage instruction: valid, sources + use flags,
//                         destination, write enable, load flag
//   ex_jump_flag          taken jump/branch resolved in EX this cycle
//   perf_clear            synchronous clear of both performance counters
//   stall, bubble, flush  pipeline control to PC / IF-ID / ID-EX
//   fwd_rs1_sel/rs2_sel   0 = register file, k = output of stage k
//   stall_count/flush_count  saturating cycle counters
module pipe_hazard_ctrl #(
  parameter  int unsigned REG_AW     = 5,
  parameter  int unsigned DEPTH      = 3,
  parameter  int unsigned LOAD_READY = 2,
  parameter  int unsigned PERF_W     = 16,
  localparam int unsigned SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic              id_rf_wen,
  input  logic              id_is_load,
  input  logic              ex_jump_flag,
  input  logic              perf_clear,
  output logic              stall,
  output logic              bubble,
  output logic              flush,
  output logic [SEL_W-1:0]  fwd_rs1_sel,
  output logic [SEL_W-1:0]  fwd_rs2_sel,
  output logic [PERF_W-1:0] stall_count,
  output logic [PERF_W-1:0] flush_count
);

  // Scoreboard entry k mirrors the instruction currently in stage k.
  logic [DEPTH:1]             vld_q, vld_d;
  logic [DEPTH:1]             wen_q, wen_d;
  logic [DEPTH:1]             ld_q, ld_d;
  logic [DEPTH:1][REG_AW-1:0] rd_q, rd_d;

  logic [DEPTH:1] m1, m2;
  logic           lu_hazard;
  logic           issue;

  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

  // Per-stage source match; x0 never creates a dependency.
  always_comb begin
    m1 = '0;
    m2 = '0;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      m1[k] = id_rs1_used && (id_rs1_addr != '0) && vld_q[k] && wen_q[k] &&
              (rd_q[k] == id_rs1_addr);
      m2[k] = id_rs2_used && (id_rs2_addr != '0) && vld_q[k] && wen_q[k] &&
              (rd_q[k] == id_rs2_addr);
    end
  end

  // Walk from oldest to youngest so the youngest producer is the last writer.
  always_comb begin
    fwd_rs1_sel = '0;
    fwd_rs2_sel = '0;
    lu_hazard   = 1'b0;
    for (int unsigned k = DEPTH; k >= 1; k--) begin
      if (m1[k]) fwd_rs1_sel = SEL_W'(k);
      if (m2[k]) fwd_rs2_sel = SEL_W'(k);
    end
    for (int unsigned k = 1; k < LOAD_READY && k <= DEPTH; k++) begin
      if ((m1[k] || m2[k]) && ld_q[k]) lu_hazard = 1'b1;
    end
  end

  // A resolved jump squashes the ID instruction, so it overrides the stall.
  assign flush  = ex_jump_flag;
  assign stall  = id_valid && !ex_jump_flag && lu_hazard;
  assign bubble = stall || flush;
  assign issue  = id_valid && !stall && !flush;

  always_comb begin
    vld_d = '0;
    wen_d = '0;
    ld_d  = '0;
    rd_d  = '0;
    for (int unsigned k = 2; k <= DEPTH; k++) begin
      vld_d[k] = vld_q[k-1];
      wen_d[k] = wen_q[k-1];
      ld_d[k]  = ld_q[k-1];
      rd_d[k]  = rd_q[k-1];
    end
    if (issue) begin
      vld_d[1] = 1'b1;
      rd_d[1]  = id_rd_addr;
      wen_d[1] = id_rf_wen && (id_rd_addr != '0);
      ld_d[1]  = id_is_load;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (perf_clear) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + PERF_W'(1);
      if (flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q       <= '0;
      wen_q       <= '0;
      ld_q        <= '0;
      rd_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      vld_q       <= vld_d;
      wen_q       <= wen_d;
      ld_q        <= ld_d;
      rd_q        <= rd_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl (DEPTH=3, LOAD_READY=2, PERF_W=4). Expected
// outputs are hand-derived per cycle, queued when the stimulus is applied and
// compared once the combinational outputs settle.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic       id_rs1_used, id_rs2_used, id_rf_wen, id_is_load;
  logic       ex_jump_flag, perf_clear;
  logic       stall, bubble, flush;
  logic [1:0] fwd_rs1_sel, fwd_rs2_sel;
  logic [3:0] stall_count, flush_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [14:0] v;
  } exp_t;

  exp_t exp_q[$];

  pipe_hazard_ctrl #(.REG_AW(5), .DEPTH(3), .LOAD_READY(2), .PERF_W(4)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd_addr(id_rd_addr), .id_rf_wen(id_rf_wen), .id_is_load(id_is_load),
    .ex_jump_flag(ex_jump_flag), .perf_clear(perf_clear),
    .stall(stall), .bubble(bubble), .flush(flush),
    .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before timeout");
    $fatal(1, "timeout");
  end

  // {stall, flush, bubble, fwd_rs1_sel, fwd_rs2_sel, stall_count, flush_count}
  function automatic logic [14:0] obs();
    return {stall, flush, bubble, fwd_rs1_sel, fwd_rs2_sel, stall_count, flush_count};
  endfunction

  function automatic void push_exp(input string n, input logic st, input logic fl,
                                   input logic bu, input logic [1:0] a,
                                   input logic [1:0] b, input logic [3:0] sc,
                                   input logic [3:0] fc);
    exp_t t;
    t.name = n;
    t.v    = {st, fl, bu, a, b, sc, fc};
    exp_q.push_back(t);
  endfunction

  task automatic drive(input logic v, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                       input logic w, input logic ld, input logic j);
    id_valid     = v;
    id_rs1_addr  = r1;
    id_rs1_used  = u1;
    id_rs2_addr  = r2;
    id_rs2_used  = u2;
    id_rd_addr   = rd;
    id_rf_wen    = w;
    id_is_load   = ld;
    ex_jump_flag = j;
  endtask

  task automatic apply_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    perf_clear = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    @(negedge clk);
    push_exp("reset_held", 0, 0, 0, 0, 0, 0, 0);
    #1; e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %015b want %015b", e.name, obs(), e.v); end
    reset = 1'b0;
    @(negedge clk);
    push_exp("reset_idle", 0, 0, 0, 0, 0, 0, 0);
    #1; e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %015b want %015b", e.name, obs(), e.v); end
    @(negedge clk);
  endtask

  task automatic test_forward();
    exp_t e;
    apply_reset();
    drive(1, 1, 1, 2, 1, 5, 1, 0, 0);  // add x5
    push_exp("fwd_add", 0, 0, 0, 0, 0, 0, 0);
    #1; e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %015b want %015b", e.name, obs(), e.v); end
    @(negedge clk);
    drive(1, 5, 1, 1, 1, 6, 1, 0, 0);  // sub x6,x5,x1
    push_exp("fwd_ex", 0, 0, 0, 1, 0, 0, 0);
    #1; e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %015b want %015b", e.name, obs(), e.v); end
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 10, 1, 0, 0); // writes x10
    push_exp("fwd_noread", 0, 0, 0, 0, 0, 0, 0);
    #1; e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %015b want %015b", e.name, obs(), e.v); end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);  // gap
    push_exp("fwd_gap", 0, 0, 0, 0, 0, 0, 0);
    #1; e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %015b want %015b", e.name, obs(), e.v); end
    @(negedge clk);
    drive(1, 10, 1, 6, 1, 0, 1, 0, 0); // x10 in MEM, x6 in WB
    push_exp("fwd_mem_wb", 0, 0, 0, 2, 3, 0, 0);
    #1; e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %015b want %015b", e.name, obs(), e.v); end
    @(negedge clk);
    drive(1, 10, 1, 6, 1, 0, 0, 0, 0); // x6 retired, x10 in WB
    push_exp("fwd_retire", 0, 0, 0, 3, 0, 0, 0);
    #1; e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %015b want %015b", e.name, obs(), e.v); end
    @(negedge clk);
    drive(1, 10, 1, 0, 1, 0, 0, 0, 0);
    push_exp("fwd_all_retired", 0, 0, 0, 0, 0, 0, 0);
    #1; e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %015b want %015b", e.name, obs(), e.v); end
    @(negedge clk);
  endtask

  task automatic test_youngest();
    exp_t e;
    apply_reset();
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0);
    push_exp("yng_first", 0, 0, 0, 0, 0, 0, 0);
    #1; e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %015b want %015b", e.name, obs(), e.v); end
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0);
    push_exp("yng_second", 0, 0, 0, 0, 0, 0, 0);
    #1; e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %015b want %015b", e.name, obs(), e.v); end
    @(negedge clk);
    drive(1, 9, 1, 9, 1, 0, 1, 1, 0); // reads x9 twice; is a load to x0
    push_exp("yng_pick1", 0, 0, 0, 1, 1, 0, 0);
    #1; e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %015b want %015b", e.name, obs(), e.v); end
    @(negedge clk);
    drive(1, 0, 1, 0, 1, 0, 0, 0, 0); // reads x0 behind a load to x0
    push_exp("yng_x0", 0, 0, 0, 0, 0, 0, 0);
    #1; e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %015b want %015b", e.name, obs(), e.v); end
    @(negedge clk);
  endtask

  task automatic test_load_use();
    exp_t e;
    apply_reset();
    drive(1, 2, 1, 0, 0, 7, 1, 1, 0); // lw x7
    push_exp("lu_lw", 0, 0, 0, 0, 0, 0, 0);
    #1; e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %015b want %015b", e.name, obs(), e.v); end
    @(negedge clk);
    drive(1, 7, 1, 7, 1, 8, 1, 0, 0); // add x8,x7,x7
    push_exp("lu_stall", 1, 0, 1, 1, 1, 0, 0);
    #1; e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %015b want %015b", e.name, obs(), e.v); end
    @(negedge clk);
    push_exp("lu_release", 0, 0, 0, 2, 2, 1, 0);  // ID held
    #1; e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %015b want %015b", e.name, obs(), e.v); end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    push_exp("lu_after", 0, 0, 0, 0, 0, 1, 0);
    #1; e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %015b want %015b", e.name, obs(), e.v); end
    @(negedge clk);
  endtask

  task automatic test_jump();
    exp_t e;
    apply_reset();
    drive(1, 0, 0, 0, 0, 3, 1, 1, 0); // lw x3
    push_exp("jmp_lw", 0, 0, 0, 0, 0, 0, 0);
    #1; e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %015b want %015b", e.name, obs(), e.v); end
    @(negedge clk);
    drive(1, 3, 1, 0, 0, 12, 1, 0, 1); // dependent in ID, jump in EX
    push_exp("jmp_flush", 0, 1, 1, 1, 0, 0, 0);
    #1; e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %015b want %015b", e.name, obs(), e.v); end
    @(negedge clk);
    drive(1, 3, 1, 12, 1, 13, 1, 0, 0); // squashed x12 must not be tracked
    push_exp("jmp_after", 0, 0, 0, 2, 0, 0, 1);
    #1; e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %015b want %015b", e.name, obs(), e.v); end
    @(negedge clk);
  endtask

  task automatic test_saturate();
    exp_t e;
    logic [3:0] s;
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      s = (i > 15) ? 4'd15 : 4'(i);
      drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
      push_exp("sat_lw", 0, 0, 0, 0, 0, s, 0);
      #1; e = exp_q.pop_front(); checks++;
      if (obs() !== e.v) begin errors++; $display("FAIL %s[%0d]: got %015b want %015b", e.name, i, obs(), e.v); end
      @(negedge clk);
      drive(1, 7, 1, 0, 0, 8, 1, 0, 0);
      push_exp("sat_stall", 1, 0, 1, 1, 0, s, 0);
      #1; e = exp_q.pop_front(); checks++;
      if (obs() !== e.v) begin errors++; $display("FAIL %s[%0d]: got %015b want %015b", e.name, i, obs(), e.v); end
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    perf_clear = 1'b1;  // clear wins over the flush increment
    push_exp("sat_clear", 0, 1, 1, 0, 0, 15, 0);
    #1; e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %015b want %015b", e.name, obs(), e.v); end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    perf_clear = 1'b0;
    push_exp("sat_cleared", 0, 0, 0, 0, 0, 0, 0);
    #1; e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %015b want %015b", e.name, obs(), e.v); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    apply_reset();
    drive(1, 0, 0, 0, 0, 3, 1, 1, 0);
    push_exp("mr_lw0", 0, 0, 0, 0, 0, 0, 0);
    #1; e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %015b want %015b", e.name, obs(), e.v); end
    @(negedge clk);
    drive(1, 3, 1, 3, 1, 4, 1, 0, 0);
    push_exp("mr_stall0", 1, 0, 1, 1, 1, 0, 0);
    #1; e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %015b want %015b", e.name, obs(), e.v); end
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 3, 1, 1, 0);
    push_exp("mr_lw1", 0, 0, 0, 0, 0, 1, 0);
    #1; e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %015b want %015b", e.name, obs(), e.v); end
    @(negedge clk);
    drive(1, 3, 1, 3, 1, 4, 1, 0, 0);
    push_exp("mr_stall1", 1, 0, 1, 1, 1, 1, 0);
    #1; e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %015b want %015b", e.name, obs(), e.v); end
    #1; reset = 1'b1;  // asynchronous, mid-cycle, dependent still in ID
    push_exp("mr_asserted", 0, 0, 0, 0, 0, 0, 0);
    #1; e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %015b want %015b", e.name, obs(), e.v); end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    push_exp("mr_released", 0, 0, 0, 0, 0, 0, 0);
    #1; e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %015b want %015b", e.name, obs(), e.v); end
    @(negedge clk);
    drive(0, 3, 1, 3, 1, 0, 0, 0, 0);  // reads x3 with nothing in flight
    push_exp("mr_empty", 0, 0, 0, 0, 0, 0, 0);
    #1; e = exp_q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %015b want %015b", e.name, obs(), e.v); end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    perf_clear = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_forward();
    test_youngest();
    test_load_use();
    test_jump();
    test_saturate();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
